// File: rtl/arb_wrr_burst.sv
// Weighted round-robin arbiter with burst locking: per-requester credits, loaded
// from the weights, bound how many bursts each requester wins per round.
module arb_wrr_burst #(
    parameter int WIDTH = 4,
    parameter int CW    = 4,
    localparam int IW   = $clog2(WIDTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WIDTH-1:0]    v_req,
    input  logic [WIDTH-1:0]    v_last,
    input  logic [WIDTH*CW-1:0] v_weight,
    input  logic                gnt_rdy,
    output logic [WIDTH-1:0]    v_grant,
    output logic                gnt_vld,
    output logic [IW-1:0]       gnt_idx
);

    typedef enum logic [1:0] {
        IDLE,
        RELOAD,
        BUSY
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] grant_q, grant_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    credit_q [WIDTH];
    logic [CW-1:0]    credit_d [WIDTH];

    logic [CW-1:0]    weight [WIDTH];
    logic [WIDTH-1:0] active;
    logic [WIDTH-1:0] elig;
    logic             pick_found;
    logic [IW-1:0]    pick_idx;
    logic [IW:0]      cand;
    logic [IW-1:0]    cur_idx;
    logic             xfer;

    // Zero-weight requesters are invisible: never eligible, never cause a reload.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            weight[i] = v_weight[i*CW +: CW];
            active[i] = v_req[i] & (weight[i] != '0);
            elig[i]   = active[i] & (credit_q[i] != '0);
        end
    end

    // Rotating priority scan starting at ptr_q; one extra bit keeps the wrap exact
    // for any WIDTH, not only powers of two.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < WIDTH; k++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(k);
            if (cand >= (IW+1)'(WIDTH)) begin
                cand = cand - (IW+1)'(WIDTH);
            end
            if (!pick_found && elig[cand[IW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        cur_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (grant_q[i]) begin
                cur_idx = IW'(i);
            end
        end
    end

    assign xfer = v_req[cur_idx] & gnt_rdy;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        credit_d = credit_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = WIDTH'(1) << pick_idx;
                    state_d = BUSY;
                end else if (|active) begin
                    state_d = RELOAD;
                end
            end
            RELOAD: begin
                credit_d = weight;
                state_d  = IDLE;
            end
            BUSY: begin
                // The lock only releases on an accepted last beat, even if req drops.
                if (xfer && v_last[cur_idx]) begin
                    if (credit_q[cur_idx] != '0) begin
                        credit_d[cur_idx] = credit_q[cur_idx] - CW'(1);
                    end
                    if (cur_idx == IW'(WIDTH-1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = cur_idx + IW'(1);
                    end
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                credit_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
        end
    end

    assign v_grant = grant_q;
    assign gnt_vld = |grant_q;
    assign gnt_idx = cur_idx;

    a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(grant_q));
    a_no_grant_outside_busy: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q != BUSY) |-> (grant_q == '0));
    a_grant_in_busy: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == BUSY) |-> $onehot(grant_q));

endmodule

// File: tb/tb_arb_wrr_burst.sv
// Randomised bench for arb_wrr_burst: a burst-level WRR model predicts the grant
// sequence and gaps, a monitor pops predictions whenever a new grant appears.
module tb_arb_wrr_burst;

    localparam int WIDTH = 4;
    localparam int CW    = 4;
    localparam int IW    = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [WIDTH-1:0]    v_req;
    logic [WIDTH-1:0]    v_last;
    logic [WIDTH*CW-1:0] v_weight;
    logic                gnt_rdy;
    logic [WIDTH-1:0]    v_grant;
    logic                gnt_vld;
    logic [IW-1:0]       gnt_idx;

    arb_wrr_burst #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .v_req    (v_req),
        .v_last   (v_last),
        .v_weight (v_weight),
        .gnt_rdy  (gnt_rdy),
        .v_grant  (v_grant),
        .gnt_vld  (gnt_vld),
        .gnt_idx  (gnt_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nCompared   = 0;
    int nMismatched = 0;

    typedef struct {
        int idx;
        int lat;
        bit first;
        int anchor;
    } exp_t;

    exp_t sbq[$];

    // Reference model state (burst granularity)
    int mCredit[WIDTH];
    int mPtr;

    // Epoch configuration
    int wCfg[WIDTH];
    int nBursts[WIDTH];
    int fixedLen;
    int maxLen;
    int rdyPct;

    // Requester driver state
    int beatsRem[WIDTH];
    int burLeft[WIDTH];
    bit pendXfer;
    int pendIdx;
    int lastXferCyc = -10;

    task automatic checkOutput(input string name, input int actual, input int expected);
        nCompared++;
        if (actual != expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic int newLen();
        if (fixedLen > 0) return fixedLen;
        return int'($urandom_range(maxLen, 1));
    endfunction

    function automatic bit epochDone();
        for (int i = 0; i < WIDTH; i++) begin
            if (wCfg[i] != 0 && burLeft[i] > 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // One cycle of requester behaviour, driven at the falling edge.
    task automatic applyStimulus();
        @(negedge clk);
        if (pendXfer) begin
            beatsRem[pendIdx]--;
            if (beatsRem[pendIdx] == 0) begin
                burLeft[pendIdx]--;
                if (burLeft[pendIdx] > 0) beatsRem[pendIdx] = newLen();
            end
            pendXfer = 1'b0;
        end
        for (int i = 0; i < WIDTH; i++) begin
            v_req[i]  = (beatsRem[i] > 0);
            v_last[i] = (beatsRem[i] == 1);
        end
        gnt_rdy = ($urandom_range(99, 0) < rdyPct);
        for (int i = 0; i < WIDTH; i++) begin
            if (v_grant[i] && v_req[i] && gnt_rdy) begin
                pendXfer = 1'b1;
                pendIdx  = i;
                if (v_last[i]) lastXferCyc = cyc + 1;
            end
        end
    endtask

    task automatic setCfg(input int w0, input int w1, input int w2, input int w3,
                          input int b0, input int b1, input int b2, input int b3,
                          input int fl, input int ml, input int rp);
        wCfg[0] = w0; wCfg[1] = w1; wCfg[2] = w2; wCfg[3] = w3;
        nBursts[0] = b0; nBursts[1] = b1; nBursts[2] = b2; nBursts[3] = b3;
        fixedLen = fl;
        maxLen   = ml;
        rdyPct   = rp;
    endtask

    // Predict the whole epoch's grant order from the WRR rules, then arm the requesters.
    task automatic startEpoch();
        int  bl[WIDTH];
        bit  first;
        bit  act;
        bit  anyElig;
        bit  reload;
        int  win;
        exp_t e;
        @(negedge clk);
        for (int i = 0; i < WIDTH; i++) begin
            v_weight[i*CW +: CW] = CW'(wCfg[i]);
            bl[i] = nBursts[i];
        end
        first = 1'b1;
        forever begin
            act     = 1'b0;
            anyElig = 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                if (bl[i] > 0 && wCfg[i] != 0) begin
                    act = 1'b1;
                    if (mCredit[i] != 0) anyElig = 1'b1;
                end
            end
            if (!act) break;
            reload = !anyElig;
            if (reload) begin
                for (int i = 0; i < WIDTH; i++) mCredit[i] = wCfg[i];
            end
            win = -1;
            for (int k = 0; k < WIDTH; k++) begin
                int j;
                j = (mPtr + k) % WIDTH;
                if (win < 0 && bl[j] > 0 && wCfg[j] != 0 && mCredit[j] != 0) win = j;
            end
            e.idx    = win;
            e.lat    = (first ? 1 : 2) + (reload ? 2 : 0);
            e.first  = first;
            e.anchor = cyc + 1;
            sbq.push_back(e);
            mCredit[win]--;
            mPtr = (win + 1) % WIDTH;
            bl[win]--;
            first = 1'b0;
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (wCfg[i] == 0) begin
                burLeft[i]  = (nBursts[i] > 0) ? 1 : 0;
                beatsRem[i] = burLeft[i];
            end else begin
                burLeft[i]  = nBursts[i];
                beatsRem[i] = (nBursts[i] > 0) ? newLen() : 0;
            end
        end
    endtask

    task automatic clearReqs();
        for (int i = 0; i < WIDTH; i++) begin
            burLeft[i]  = 0;
            beatsRem[i] = 0;
        end
        repeat (3) applyStimulus();
    endtask

    task automatic runEpoch();
        int t;
        startEpoch();
        t = 0;
        while (!epochDone() && t < 3000) begin
            applyStimulus();
            t++;
        end
        checkOutput("epoch_done", int'(epochDone()), 1);
        repeat (2) applyStimulus();
        checkOutput("sb_leftover", sbq.size(), 0);
        sbq.delete();
        clearReqs();
    endtask

    task automatic resetModel();
        for (int i = 0; i < WIDTH; i++) begin
            mCredit[i]  = 0;
            burLeft[i]  = 0;
            beatsRem[i] = 0;
        end
        mPtr     = 0;
        pendXfer = 1'b0;
        sbq.delete();
    endtask

    // Monitor: invariants every cycle, scoreboard pop on each new grant.
    bit                prevVld   = 1'b0;
    logic [WIDTH-1:0]  prevGrant = '0;
    int                lastHighCyc = 0;
    int                monIdx;
    exp_t              monExp;

    always @(negedge clk) begin
        if (!rst_n) begin
            prevVld   = 1'b0;
            prevGrant = '0;
        end else begin
            monIdx = 0;
            for (int i = 0; i < WIDTH; i++) if (v_grant[i]) monIdx = i;
            checkOutput("onehot0", int'($countones(v_grant) <= 1), 1);
            checkOutput("vld_consistent", int'(gnt_vld), int'(|v_grant));
            checkOutput("idx_consistent", int'(gnt_idx), monIdx);
            if (gnt_vld && !prevVld) begin
                if (sbq.size() == 0) begin
                    checkOutput("unexpected_grant", int'(v_grant), 0);
                end else begin
                    monExp = sbq.pop_front();
                    checkOutput("grant_idx", int'(gnt_idx), monExp.idx);
                    checkOutput("grant_onehot", int'(v_grant), 1 << monExp.idx);
                    checkOutput("grant_latency",
                                monExp.first ? (cyc - monExp.anchor) : (cyc - lastHighCyc),
                                monExp.lat);
                end
            end else if (gnt_vld && prevVld) begin
                checkOutput("grant_hold", int'(v_grant), int'(prevGrant));
            end else if (!gnt_vld && prevVld) begin
                checkOutput("release_on_last", cyc, lastXferCyc);
            end
            if (gnt_vld) lastHighCyc = cyc;
            prevVld   = gnt_vld;
            prevGrant = v_grant;
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit found;
        rst_n    = 1'b0;
        v_req    = 4'hF;
        v_last   = '0;
        gnt_rdy  = 1'b0;
        v_weight = '0;
        for (int i = 0; i < WIDTH; i++) v_weight[i*CW +: CW] = CW'(1);
        setCfg(1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 100);
        resetModel();
        repeat (3) @(negedge clk);
        checkOutput("reset_grant", int'(v_grant), 0);
        checkOutput("reset_vld", int'(gnt_vld), 0);
        checkOutput("reset_idx", int'(gnt_idx), 0);
        v_req = '0;
        @(posedge clk);
        #2 rst_n = 1'b1;

        $display("[TB] equal weights, single-beat bursts");
        setCfg(1, 1, 1, 1, 2, 2, 2, 2, 1, 1, 100);
        runEpoch();

        $display("[TB] weights 2/1/0/1, requester 2 has zero weight");
        setCfg(2, 1, 0, 1, 4, 2, 1, 2, 1, 1, 100);
        runEpoch();

        $display("[TB] multi-beat bursts with back-pressure");
        setCfg(1, 1, 1, 1, 1, 1, 0, 0, 3, 3, 40);
        runEpoch();

        $display("[TB] randomised epochs");
        for (int n = 0; n < 25; n++) begin
            setCfg(int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                   int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                   int'($urandom_range(4, 0)), int'($urandom_range(4, 0)),
                   int'($urandom_range(4, 0)), int'($urandom_range(4, 0)),
                   0, 4, int'($urandom_range(100, 50)));
            runEpoch();
        end

        $display("[TB] reset during a burst of requester 2");
        setCfg(1, 1, 1, 1, 0, 0, 1, 0, 20, 20, 50);
        startEpoch();
        found = 1'b0;
        for (int t = 0; t < 200 && !found; t++) begin
            applyStimulus();
            if (v_grant == 4'b0100) found = 1'b1;
        end
        checkOutput("reach_grant2", int'(found), 1);
        applyStimulus();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_grant", int'(v_grant), 0);
        checkOutput("async_reset_vld", int'(gnt_vld), 0);
        checkOutput("async_reset_idx", int'(gnt_idx), 0);
        resetModel();
        v_req  = '0;
        v_last = '0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        $display("[TB] only a zero-weight requester active, then requester 0 joins");
        setCfg(1, 1, 0, 1, 0, 0, 1, 0, 1, 1, 100);
        for (int i = 0; i < WIDTH; i++) v_weight[i*CW +: CW] = CW'(wCfg[i]);
        burLeft[2]  = 1;
        beatsRem[2] = 1;
        for (int n = 0; n < 10; n++) begin
            applyStimulus();
            checkOutput("zero_weight_idle", int'(gnt_vld), 0);
        end
        setCfg(1, 1, 0, 1, 1, 0, 1, 0, 1, 1, 100);
        runEpoch();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
